// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - command/status bundle between fetch control and the PC sequencer
interface pc_sequencer_if #(
   parameter int ADDR_W = 8,
   parameter int OFF_W  = 8,
   parameter int SP_W   = 3
);
   logic              en;
   logic [2:0]        op;
   logic              step_long;
   logic [ADDR_W-1:0] target;
   logic [OFF_W-1:0]  offset;
   logic              err_clr;
   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] pc_plus1;
   logic [SP_W-1:0]   sp;
   logic              stack_full;
   logic              ovf_err;
   logic              unf_err;

   modport master (
      output en, op, step_long, target, offset, err_clr,
      input  pc, pc_plus1, sp, stack_full, ovf_err, unf_err
   );

   modport slave (
      input  en, op, step_long, target, offset, err_clr,
      output pc, pc_plus1, sp, stack_full, ovf_err, unf_err
   );
endinterface

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch-stage program counter with call/return stack
module pc_sequencer #(
   parameter int ADDR_W      = 8,
   parameter int OFF_W       = 8,
   parameter int STEP_SHORT  = 1,
   parameter int STEP_LONG   = 2,
   parameter int RESET_VEC   = 0,
   parameter int STACK_DEPTH = 4
) (
   input logic           clk,
   input logic           reset,
   pc_sequencer_if.slave bus
);
   localparam int SP_W  = $clog2(STACK_DEPTH + 1);
   localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

   localparam logic [2:0] OP_INC    = 3'd1;
   localparam logic [2:0] OP_JUMP   = 3'd2;
   localparam logic [2:0] OP_BRANCH = 3'd3;
   localparam logic [2:0] OP_CALL   = 3'd4;
   localparam logic [2:0] OP_RET    = 3'd5;

   logic [ADDR_W-1:0] pc_q, pc_next;
   logic [SP_W-1:0]   sp_q, sp_next;
   logic              ovf_q, unf_q;
   logic              push, ovf_set, unf_set;
   logic [ADDR_W-1:0] stack [STACK_DEPTH];

   logic [ADDR_W-1:0] step, ret_addr, off_ext;
   logic [IDX_W-1:0]  push_idx, pop_idx;

   assign step     = bus.step_long ? ADDR_W'(STEP_LONG) : ADDR_W'(STEP_SHORT);
   assign ret_addr = pc_q + step;
   // Sign-extending size cast; truncation also keeps the modulo-2**ADDR_W rule.
   assign off_ext  = ADDR_W'($signed(bus.offset));
   assign push_idx = IDX_W'(sp_q);
   assign pop_idx  = IDX_W'(sp_q - SP_W'(1));

   always_comb begin
      pc_next = pc_q;
      sp_next = sp_q;
      push    = 1'b0;
      ovf_set = 1'b0;
      unf_set = 1'b0;
      case (bus.op)
         OP_INC:    pc_next = pc_q + step;
         OP_JUMP:   pc_next = bus.target;
         OP_BRANCH: pc_next = pc_q + off_ext;
         OP_CALL: begin
            if (sp_q < SP_W'(STACK_DEPTH)) begin
               push    = 1'b1;
               sp_next = sp_q + SP_W'(1);
               pc_next = bus.target;
            end else begin
               ovf_set = 1'b1;
            end
         end
         OP_RET: begin
            if (sp_q != '0) begin
               pc_next = stack[pop_idx];
               sp_next = sp_q - SP_W'(1);
            end else begin
               unf_set = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q  <= ADDR_W'(RESET_VEC);
         sp_q  <= '0;
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else if (bus.en) begin
         pc_q  <= pc_next;
         sp_q  <= sp_next;
         ovf_q <= ovf_set | (ovf_q & ~bus.err_clr);
         unf_q <= unf_set | (unf_q & ~bus.err_clr);
      end
   end

   // Stack storage carries no reset; sp alone defines which entries are valid.
   always_ff @(posedge clk) begin
      if (!reset && bus.en && push)
         stack[push_idx] <= ret_addr;
   end

   assign bus.pc         = pc_q;
   assign bus.pc_plus1   = pc_q + ADDR_W'(1);
   assign bus.sp         = sp_q;
   assign bus.stack_full = (sp_q == SP_W'(STACK_DEPTH));
   assign bus.ovf_err    = ovf_q;
   assign bus.unf_err    = unf_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed scoreboard bench for pc_sequencer
module tb_pc_sequencer;
   localparam logic [2:0] HOLD = 3'd0, INC = 3'd1, JUMP = 3'd2, BRANCH = 3'd3,
                          CALL = 3'd4, RET = 3'd5;

   typedef struct {
      string      tag;
      logic [7:0] pc;
      logic [2:0] sp;
      logic       ovf;
      logic       unf;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   vectors = 0;
   int   miscompares = 0;
   exp_t sb[$];

   pc_sequencer_if #(.ADDR_W(8), .OFF_W(8), .SP_W(3)) bus ();

   pc_sequencer #(
      .ADDR_W(8), .OFF_W(8), .STEP_SHORT(1), .STEP_LONG(2),
      .RESET_VEC(0), .STACK_DEPTH(4)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish within time limit");
      $fatal(1, "timeout");
   end

   task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle, queue its expected outcome, then retire it after the edge.
   task automatic step(input string tag, input logic e, input logic r, input logic [2:0] o,
                       input logic sl, input logic [7:0] tgt, input logic [7:0] off,
                       input logic clr, input logic [7:0] epc, input int esp,
                       input logic eovf, input logic eunf);
      exp_t x;
      @(negedge clk);
      reset         = r;
      bus.en        = e;
      bus.op        = o;
      bus.step_long = sl;
      bus.target    = tgt;
      bus.offset    = off;
      bus.err_clr   = clr;
      sb.push_back('{tag, epc, 3'(esp), eovf, eunf});
      @(posedge clk);
      #1;
      x = sb.pop_front();
      cmp({x.tag, ".pc"},       bus.pc,                x.pc);
      cmp({x.tag, ".pc_plus1"}, bus.pc_plus1,          x.pc + 8'd1);
      cmp({x.tag, ".sp"},       {5'd0, bus.sp},        {5'd0, x.sp});
      cmp({x.tag, ".full"},     {7'd0, bus.stack_full}, {7'd0, (x.sp == 3'd4)});
      cmp({x.tag, ".ovf"},      {7'd0, bus.ovf_err},   {7'd0, x.ovf});
      cmp({x.tag, ".unf"},      {7'd0, bus.unf_err},   {7'd0, x.unf});
   endtask

   initial begin
      bus.en = 1'b0; bus.op = HOLD; bus.step_long = 1'b0;
      bus.target = '0; bus.offset = '0; bus.err_clr = 1'b0;

      step("reset",   0, 1, HOLD, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 0);
      step("inc_s1",  1, 0, INC,  0, 8'h00, 8'h00, 0, 8'h01, 0, 0, 0);
      step("inc_s2",  1, 0, INC,  0, 8'h00, 8'h00, 0, 8'h02, 0, 0, 0);
      step("inc_s3",  1, 0, INC,  0, 8'h00, 8'h00, 0, 8'h03, 0, 0, 0);
      step("inc_l1",  1, 0, INC,  1, 8'h00, 8'h00, 0, 8'h05, 0, 0, 0);
      step("inc_l2",  1, 0, INC,  1, 8'h00, 8'h00, 0, 8'h07, 0, 0, 0);

      step("jmp_fe",  1, 0, JUMP,   0, 8'hFE, 8'h00, 0, 8'hFE, 0, 0, 0);
      step("incwrap", 1, 0, INC,    1, 8'h00, 8'h00, 0, 8'h00, 0, 0, 0);
      step("br_neg",  1, 0, BRANCH, 0, 8'h00, 8'hFC, 0, 8'hFC, 0, 0, 0);
      step("jmp_02",  1, 0, JUMP,   0, 8'h02, 8'h00, 0, 8'h02, 0, 0, 0);
      step("br_wrap", 1, 0, BRANCH, 0, 8'h00, 8'hFC, 0, 8'hFE, 0, 0, 0);
      step("br_pos",  1, 0, BRANCH, 0, 8'h00, 8'h05, 0, 8'h03, 0, 0, 0);
      step("op6",     1, 0, 3'd6,   1, 8'h55, 8'h11, 0, 8'h03, 0, 0, 0);
      step("op7",     1, 0, 3'd7,   1, 8'h55, 8'h11, 0, 8'h03, 0, 0, 0);
      step("hold",    1, 0, HOLD,   1, 8'h55, 8'h11, 0, 8'h03, 0, 0, 0);

      step("jmp_10",  1, 0, JUMP, 0, 8'h10, 8'h00, 0, 8'h10, 0, 0, 0);
      step("call_s",  1, 0, CALL, 0, 8'h40, 8'h00, 0, 8'h40, 1, 0, 0);
      step("call_l",  1, 0, CALL, 1, 8'h80, 8'h00, 0, 8'h80, 2, 0, 0);
      step("ret1",    1, 0, RET,  0, 8'h00, 8'h00, 0, 8'h42, 1, 0, 0);
      step("ret2",    1, 0, RET,  0, 8'h00, 8'h00, 0, 8'h11, 0, 0, 0);

      step("jmp_00",  1, 0, JUMP, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 0);
      step("fill1",   1, 0, CALL, 0, 8'h10, 8'h00, 0, 8'h10, 1, 0, 0);
      step("fill2",   1, 0, CALL, 0, 8'h20, 8'h00, 0, 8'h20, 2, 0, 0);
      step("fill3",   1, 0, CALL, 0, 8'h30, 8'h00, 0, 8'h30, 3, 0, 0);
      step("fill4",   1, 0, CALL, 0, 8'h40, 8'h00, 0, 8'h40, 4, 0, 0);
      step("ovf",     1, 0, CALL, 0, 8'h50, 8'h00, 0, 8'h40, 4, 1, 0);
      step("ovf_clr", 1, 0, HOLD, 0, 8'h00, 8'h00, 1, 8'h40, 4, 0, 0);
      step("set_win", 1, 0, CALL, 0, 8'h50, 8'h00, 1, 8'h40, 4, 1, 0);
      step("ovf_clr2",1, 0, HOLD, 0, 8'h00, 8'h00, 1, 8'h40, 4, 0, 0);
      step("pop4",    1, 0, RET,  0, 8'h00, 8'h00, 0, 8'h31, 3, 0, 0);
      step("pop3",    1, 0, RET,  0, 8'h00, 8'h00, 0, 8'h21, 2, 0, 0);
      step("pop2",    1, 0, RET,  0, 8'h00, 8'h00, 0, 8'h11, 1, 0, 0);
      step("pop1",    1, 0, RET,  0, 8'h00, 8'h00, 0, 8'h01, 0, 0, 0);
      step("unf",     1, 0, RET,  0, 8'h00, 8'h00, 0, 8'h01, 0, 0, 1);
      step("clr_off", 0, 0, HOLD, 0, 8'h00, 8'h00, 1, 8'h01, 0, 0, 1);
      step("unf_clr", 1, 0, HOLD, 0, 8'h00, 8'h00, 1, 8'h01, 0, 0, 0);

      step("call_70", 1, 0, CALL, 0, 8'h70, 8'h00, 0, 8'h70, 1, 0, 0);
      for (int i = 0; i < 3; i++)
         step("frozen", 0, 0, INC, 0, 8'h00, 8'h00, 0, 8'h70, 1, 0, 0);
      step("frz_call",0, 0, CALL, 0, 8'h99, 8'h00, 0, 8'h70, 1, 0, 0);
      step("rst_en0", 0, 1, INC,  0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 0);

      step("jmp_ff",  1, 0, JUMP, 0, 8'hFF, 8'h00, 0, 8'hFF, 0, 0, 0);
      step("inc_ff",  1, 0, INC,  0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 0);
      step("jmp_ff2", 1, 0, JUMP, 0, 8'hFF, 8'h00, 0, 8'hFF, 0, 0, 0);
      step("call_wr", 1, 0, CALL, 1, 8'h20, 8'h00, 0, 8'h20, 1, 0, 0);
      step("ret_wr",  1, 0, RET,  0, 8'h00, 8'h00, 0, 8'h01, 0, 0, 0);

      step("r_fill1", 1, 0, CALL, 0, 8'h10, 8'h00, 0, 8'h10, 1, 0, 0);
      step("r_fill2", 1, 0, CALL, 0, 8'h20, 8'h00, 0, 8'h20, 2, 0, 0);
      step("r_fill3", 1, 0, CALL, 0, 8'h30, 8'h00, 0, 8'h30, 3, 0, 0);
      step("r_fill4", 1, 0, CALL, 0, 8'h40, 8'h00, 0, 8'h40, 4, 0, 0);
      step("r_ovf",   1, 0, CALL, 0, 8'h50, 8'h00, 0, 8'h40, 4, 1, 0);
      step("r_pop4",  1, 0, RET,  0, 8'h00, 8'h00, 0, 8'h31, 3, 1, 0);
      step("r_pop3",  1, 0, RET,  0, 8'h00, 8'h00, 0, 8'h21, 2, 1, 0);
      step("rst_call",1, 1, CALL, 0, 8'h60, 8'h00, 0, 8'h00, 0, 0, 0);
      step("ret_post",1, 0, RET,  0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
